// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate: FSM state encoding and
// active-low 7-segment patterns ({g,f,e,d,c,b,a}).
package parking_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ENTRY_OPEN = 2'd1,
      EXIT_OPEN  = 2'd2,
      CLOSE      = 2'd3
   } state_t;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD digit to active-low 7-segment decoder; codes 10..15
// blank the display.
module seven_seg_decoder
   import parking_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/parking_gate_occupancy.sv
// Gate controller downstream of the password FSM: opens on entry grant or exit
// request, closes on a car pass or timeout, and keeps a saturating lot count.
module parking_gate_occupancy
   import parking_pkg::*;
#(
   parameter int CAPACITY     = 20,
   parameter int GATE_TIMEOUT = 16,
   parameter int CNT_W        = 7
)
(
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             entry_grant,
   input  logic             exit_req,
   input  logic             car_in_sensor,
   input  logic             car_out_sensor,
   output logic             gate_open,
   output logic [CNT_W-1:0] occupancy,
   output logic             full,
   output logic             empty,
   output logic             entry_denied,
   output logic [6:0]       H1,
   output logic [6:0]       H2
);

   localparam int               TMR_W    = (GATE_TIMEOUT > 2) ? $clog2(GATE_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);
   localparam logic [CNT_W-1:0] TEN      = CNT_W'(10);

   state_t           state, state_nxt;
   logic [TMR_W-1:0] timer, timer_nxt;
   logic [CNT_W-1:0] occ_nxt;
   logic             denied_nxt;
   logic             in_s_q, out_s_q;
   logic             in_edge, out_edge;
   logic [CNT_W-1:0] free;
   logic [3:0]       tens, units;

   assign in_edge  = car_in_sensor  & ~in_s_q;
   assign out_edge = car_out_sensor & ~out_s_q;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state        <= IDLE;
         timer        <= '0;
         occupancy    <= '0;
         in_s_q       <= 1'b0;
         out_s_q      <= 1'b0;
         entry_denied <= 1'b0;
      end else begin
         state        <= state_nxt;
         timer        <= timer_nxt;
         occupancy    <= occ_nxt;
         in_s_q       <= car_in_sensor;
         out_s_q      <= car_out_sensor;
         entry_denied <= denied_nxt;
      end
   end

   // Exit requests take priority over a simultaneous grant; the grant is dropped.
   always_comb begin
      state_nxt  = state;
      timer_nxt  = timer;
      occ_nxt    = occupancy;
      denied_nxt = 1'b0;
      case (state)
         IDLE: begin
            timer_nxt = '0;
            if (exit_req && !empty) begin
               state_nxt = EXIT_OPEN;
            end else if (entry_grant && !full) begin
               state_nxt = ENTRY_OPEN;
            end else if (entry_grant) begin
               denied_nxt = 1'b1;
            end
         end
         ENTRY_OPEN: begin
            timer_nxt = timer + 1'b1;
            if (in_edge) begin
               state_nxt = CLOSE;
               if (!full) occ_nxt = occupancy + 1'b1;
            end else if (timer == TMR_LAST) begin
               state_nxt = CLOSE;
            end
         end
         EXIT_OPEN: begin
            timer_nxt = timer + 1'b1;
            if (out_edge) begin
               state_nxt = CLOSE;
               if (!empty) occ_nxt = occupancy - 1'b1;
            end else if (timer == TMR_LAST) begin
               state_nxt = CLOSE;
            end
         end
         CLOSE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign gate_open = (state == ENTRY_OPEN) || (state == EXIT_OPEN);
   assign full      = (occupancy == CAP);
   assign empty     = (occupancy == '0);
   assign free      = CAP - occupancy;
   assign tens      = 4'(free / TEN);
   assign units     = 4'(free % TEN);

   seven_seg_decoder u_tens (
      .digit (tens),
      .seg   (H1)
   );

   seven_seg_decoder u_units (
      .digit (units),
      .seg   (H2)
   );

endmodule

// File: tb/tb_parking_gate_occupancy.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a monitor
// compares them on the falling edge of the matching cycle.
module tb_parking_gate_occupancy;

   localparam int S0 = 'h40, S1 = 'h79, S2 = 'h24, S5 = 'h12, S6 = 'h02, S9 = 'h10;
   localparam int GATE = 0, OCC = 1, FULL = 2, EMPTY = 3, DENY = 4, HT = 5, HU = 6;

   logic       CLOCK = 1'b0;
   logic       RESET = 1'b1;
   logic       entry_grant = 1'b0;
   logic       exit_req = 1'b0;
   logic       car_in_sensor = 1'b0;
   logic       car_out_sensor = 1'b0;
   logic       gate_open;
   logic [6:0] occupancy;
   logic       full, empty, entry_denied;
   logic [6:0] H1, H2;

   parking_gate_occupancy #(.CAPACITY(20), .GATE_TIMEOUT(16), .CNT_W(7)) dut (
      .CLOCK          (CLOCK),
      .RESET          (RESET),
      .entry_grant    (entry_grant),
      .exit_req       (exit_req),
      .car_in_sensor  (car_in_sensor),
      .car_out_sensor (car_out_sensor),
      .gate_open      (gate_open),
      .occupancy      (occupancy),
      .full           (full),
      .empty          (empty),
      .entry_denied   (entry_denied),
      .H1             (H1),
      .H2             (H2)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct {
      int at;
      int sig;
      int val;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   initial forever begin
      @(posedge CLOCK);
      cyc++;
   end

   function automatic int actual(int sig);
      case (sig)
         GATE:    return int'(gate_open);
         OCC:     return int'(occupancy);
         FULL:    return int'(full);
         EMPTY:   return int'(empty);
         DENY:    return int'(entry_denied);
         HT:      return int'(H1);
         default: return int'(H2);
      endcase
   endfunction

   function automatic string sname(int sig);
      case (sig)
         GATE:    return "gate_open";
         OCC:     return "occupancy";
         FULL:    return "full";
         EMPTY:   return "empty";
         DENY:    return "entry_denied";
         HT:      return "H1";
         default: return "H2";
      endcase
   endfunction

   task automatic expect_sig(input int dc, input int sig, input int val);
      exp_t e;
      e.at  = cyc + dc;
      e.sig = sig;
      e.val = val;
      sbq.push_back(e);
   endtask

   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   // Monitor: compare every expectation due in the current cycle.
   initial forever begin
      @(negedge CLOCK);
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (sbq[i].at == cyc) begin
            int act;
            act = actual(sbq[i].sig);
            checks++;
            if (act != sbq[i].val) begin
               errors++;
               $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h",
                        sname(sbq[i].sig), cyc, act, sbq[i].val);
            end
            sbq.delete(i);
         end else if (sbq[i].at < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s cycle %0d: never sampled, expected 0x%0h",
                     sname(sbq[i].sig), sbq[i].at, sbq[i].val);
            sbq.delete(i);
         end
      end
   end

   initial begin
      // Reset for three cycles, then idle state.
      repeat (3) step();
      RESET = 1'b0;
      expect_sig(0, OCC, 0);
      expect_sig(0, EMPTY, 1);
      expect_sig(0, FULL, 0);
      expect_sig(0, GATE, 0);
      expect_sig(0, DENY, 0);
      expect_sig(0, HT, S2);
      expect_sig(0, HU, S0);
      repeat (2) step();

      // Grant, car passes on the fourth open cycle.
      entry_grant = 1'b1;
      expect_sig(0, GATE, 0);
      for (int d = 1; d <= 4; d++) expect_sig(d, GATE, 1);
      expect_sig(1, DENY, 0);
      expect_sig(4, OCC, 0);
      expect_sig(5, GATE, 0);
      expect_sig(5, OCC, 1);
      expect_sig(5, HT, S1);
      expect_sig(5, HU, S9);
      expect_sig(6, GATE, 0);
      step();
      entry_grant = 1'b0;
      repeat (3) step();
      car_in_sensor = 1'b1;
      repeat (3) step();
      car_in_sensor = 1'b0;
      repeat (2) step();

      // Grant with no car: open exactly 16 cycles.
      entry_grant = 1'b1;
      for (int d = 1; d <= 16; d++) expect_sig(d, GATE, 1);
      expect_sig(17, GATE, 0);
      expect_sig(18, GATE, 0);
      expect_sig(17, OCC, 1);
      step();
      entry_grant = 1'b0;
      repeat (19) step();

      // Pass edge on the timeout cycle is still counted.
      entry_grant = 1'b1;
      expect_sig(16, GATE, 1);
      expect_sig(17, GATE, 0);
      expect_sig(17, OCC, 2);
      step();
      entry_grant = 1'b0;
      repeat (15) step();
      car_in_sensor = 1'b1;
      step();
      car_in_sensor = 1'b0;
      repeat (2) step();

      // Fill the lot to capacity.
      for (int i = 0; i < 18; i++) begin
         expect_sig(0, OCC, 2 + i);
         entry_grant = 1'b1;
         step();
         entry_grant = 1'b0;
         car_in_sensor = 1'b1;
         step();
         car_in_sensor = 1'b0;
         step();
      end
      expect_sig(0, OCC, 20);
      expect_sig(0, FULL, 1);
      expect_sig(0, EMPTY, 0);
      expect_sig(0, HT, S0);
      expect_sig(0, HU, S0);

      // Grant while full is denied for one cycle.
      entry_grant = 1'b1;
      expect_sig(1, DENY, 1);
      expect_sig(2, DENY, 0);
      expect_sig(1, GATE, 0);
      expect_sig(2, GATE, 0);
      expect_sig(2, OCC, 20);
      step();
      entry_grant = 1'b0;
      repeat (2) step();

      // Drain down to five cars.
      for (int i = 0; i < 15; i++) begin
         expect_sig(0, OCC, 20 - i);
         exit_req = 1'b1;
         step();
         exit_req = 1'b0;
         car_out_sensor = 1'b1;
         step();
         car_out_sensor = 1'b0;
         step();
      end
      expect_sig(0, OCC, 5);
      expect_sig(0, HT, S1);
      expect_sig(0, HU, S5);

      // Simultaneous grant and exit: exit wins, entry sensor ignored.
      entry_grant = 1'b1;
      exit_req = 1'b1;
      expect_sig(1, GATE, 1);
      expect_sig(2, GATE, 1);
      expect_sig(2, OCC, 5);
      expect_sig(3, OCC, 4);
      expect_sig(3, GATE, 0);
      expect_sig(4, GATE, 0);
      expect_sig(5, GATE, 0);
      expect_sig(5, HT, S1);
      expect_sig(5, HU, S6);
      step();
      entry_grant = 1'b0;
      exit_req = 1'b0;
      car_in_sensor = 1'b1;
      step();
      car_in_sensor = 1'b0;
      car_out_sensor = 1'b1;
      step();
      car_out_sensor = 1'b0;
      repeat (3) step();

      // One more exit to reach three cars.
      exit_req = 1'b1;
      step();
      exit_req = 1'b0;
      car_out_sensor = 1'b1;
      step();
      car_out_sensor = 1'b0;
      step();
      expect_sig(0, OCC, 3);

      // Reset while the entry gate is open.
      entry_grant = 1'b1;
      expect_sig(1, GATE, 1);
      step();
      entry_grant = 1'b0;
      step();
      RESET = 1'b1;
      expect_sig(0, GATE, 0);
      expect_sig(0, OCC, 0);
      expect_sig(0, EMPTY, 1);
      expect_sig(0, HT, S2);
      expect_sig(0, HU, S0);
      step();
      RESET = 1'b0;
      step();

      // Exit request while empty is ignored.
      exit_req = 1'b1;
      expect_sig(1, GATE, 0);
      expect_sig(2, GATE, 0);
      expect_sig(2, OCC, 0);
      expect_sig(2, EMPTY, 1);
      step();
      exit_req = 1'b0;
      repeat (3) step();

      for (int w = 0; w < 40 && sbq.size() != 0; w++) step();
      if (sbq.size() != 0) begin
         $display("FAIL scoreboard: %0d expectations left unchecked, required 0", sbq.size());
         checks += sbq.size();
         errors += sbq.size();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
